// File: rtl/mem_ctrl_pkg.sv
// Shared widths, size codes and state encodings for the
// byte-serial memory controller.
package mem_ctrl_pkg;

    localparam int RAM_ADDR_W = 17;
    localparam int REG_W      = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        logic [2:0] n;
        n = 3'd4;
        if (size == SZ_BYTE) n = 3'd1;
        else if (size == SZ_HALF) n = 3'd2;
        return n;
    endfunction

endpackage

// File: rtl/mem_ctrl_load_ext.sv
// Zero/sign extension of an assembled little-endian load word
// according to the access size.
module mem_ctrl_load_ext
    import mem_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] i_word,
    input  logic [1:0]       i_size,
    input  logic             i_sext,
    output logic [REG_W-1:0] o_word
);

    always_comb begin
        o_word = i_word;
        unique case (i_size)
            SZ_BYTE: o_word = {{24{i_sext & i_word[7]}}, i_word[7:0]};
            SZ_HALF: o_word = {{16{i_sext & i_word[15]}}, i_word[15:0]};
            default: o_word = i_word;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating fetch and data channels.
// Optional alignment check enabled by MEM_CTRL_MISALIGN_CHK_EN.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = REG_W
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    output logic              if_done_o,
    output logic [DATA_W-1:0] if_data_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic [1:0]        mem_size_i,
    input  logic              mem_sext_i,
    output logic              mem_done_o,
    output logic [DATA_W-1:0] mem_rdata_o,
`ifdef MEM_CTRL_MISALIGN_CHK_EN
    output logic              mem_misalign_o,
`endif
    output logic              busy_o,
    input  logic [7:0]        ram_din_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [7:0]        ram_dout_o,
    output logic              ram_wr_o
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_owner_mem;
    logic [1:0]          r_size;
    logic                r_sext;
    logic [ADDR_W-1:0]   r_base;
    logic [DATA_W-1:0]   r_wdata;
    logic [2:0]          r_cnt;
    logic [DATA_W-1:0]   r_asm;
    logic [DATA_W-1:0]   r_if_data;
    logic [DATA_W-1:0]   r_mem_rdata;
    logic [2:0]          w_nbytes;
    logic [1:0]          w_lane;
    logic [DATA_W-1:0]   w_asm_nxt;
    logic [DATA_W-1:0]   w_ext;
    logic                w_mis;
    logic                w_unused;

    assign w_unused = ^{if_addr_i[31:ADDR_W], mem_addr_i[31:ADDR_W]};
    assign w_nbytes = size_bytes(r_size);

`ifdef MEM_CTRL_MISALIGN_CHK_EN
    logic r_mis;
    assign w_mis = ((mem_size_i == SZ_HALF) && mem_addr_i[0])
                 || ((mem_size_i[1] == 1'b1) && (mem_addr_i[1:0] != 2'b00));
    assign mem_misalign_o = (r_state == S_DONE) && r_mis;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_mis <= 1'b0;
        else if (r_state == S_IDLE) r_mis <= mem_req_i && w_mis;
    end
`else
    assign w_mis = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (mem_req_i) begin
                    if (w_mis) w_state_nxt = S_DONE;
                    else if (mem_we_i) w_state_nxt = S_WRITE;
                    else w_state_nxt = S_READ;
                end else if (if_req_i) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: if (r_cnt == w_nbytes) w_state_nxt = S_DONE;
            S_WRITE: if (r_cnt == w_nbytes - 3'd1) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else r_state <= w_state_nxt;
    end

    // Byte returned now belongs to the address driven last cycle.
    assign w_lane = r_cnt[1:0] - 2'd1;

    always_comb begin
        w_asm_nxt = r_asm;
        w_asm_nxt[{w_lane, 3'b000} +: 8] = ram_din_i;
    end

    mem_ctrl_load_ext u_load_ext (
        .i_word (w_asm_nxt),
        .i_size (r_size),
        .i_sext (r_sext),
        .o_word (w_ext)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner_mem <= 1'b0;
            r_size      <= SZ_BYTE;
            r_sext      <= 1'b0;
            r_base      <= '0;
            r_wdata     <= '0;
            r_cnt       <= 3'd0;
            r_asm       <= '0;
            r_if_data   <= '0;
            r_mem_rdata <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_cnt <= 3'd0;
                    r_asm <= '0;
                    if (mem_req_i) begin
                        r_owner_mem <= 1'b1;
                        r_size      <= mem_size_i;
                        r_sext      <= mem_sext_i;
                        r_base      <= mem_addr_i[ADDR_W-1:0];
                        r_wdata     <= mem_wdata_i;
                        if (w_mis) r_mem_rdata <= '0;
                    end else if (if_req_i) begin
                        r_owner_mem <= 1'b0;
                        r_size      <= SZ_WORD;
                        r_sext      <= 1'b0;
                        r_base      <= if_addr_i[ADDR_W-1:0];
                    end
                end
                S_READ: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt != 3'd0) r_asm <= w_asm_nxt;
                    if (r_cnt == w_nbytes) begin
                        if (r_owner_mem) r_mem_rdata <= w_ext;
                        else r_if_data <= w_asm_nxt;
                    end
                end
                S_WRITE: r_cnt <= r_cnt + 3'd1;
                default: r_cnt <= 3'd0;
            endcase
        end
    end

    assign busy_o      = (r_state != S_IDLE);
    assign if_done_o   = (r_state == S_DONE) && !r_owner_mem;
    assign mem_done_o  = (r_state == S_DONE) && r_owner_mem;
    assign if_data_o   = r_if_data;
    assign mem_rdata_o = r_mem_rdata;
    assign ram_wr_o    = (r_state == S_WRITE);
    assign ram_addr_o  = ((r_state == S_READ) || (r_state == S_WRITE))
                       ? r_base + ADDR_W'(r_cnt) : '0;
    assign ram_dout_o  = (r_state == S_WRITE)
                       ? r_wdata[{r_cnt[1:0], 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl with a synchronous byte RAM
// model and an expected-result queue per request.
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_done_o;
    logic [31:0] if_data_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [1:0]  mem_size_i;
    logic        mem_sext_i;
    logic        mem_done_o;
    logic [31:0] mem_rdata_o;
    logic        busy_o;
    logic [7:0]  ram_din_i;
    logic [16:0] ram_addr_o;
    logic [7:0]  ram_dout_o;
    logic        ram_wr_o;
`ifdef MEM_CTRL_MISALIGN_CHK_EN
    logic        mem_misalign_o;
`endif

    logic [7:0]  ram [0:(1<<17)-1];
    logic        tb_we;
    logic [16:0] tb_waddr;
    logic [7:0]  tb_wdata;

    int n_checks;
    int n_pass;
    logic [31:0] sb[$];

    mem_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_done_o   (if_done_o),
        .if_data_o   (if_data_o),
        .mem_req_i   (mem_req_i),
        .mem_we_i    (mem_we_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_size_i  (mem_size_i),
        .mem_sext_i  (mem_sext_i),
        .mem_done_o  (mem_done_o),
        .mem_rdata_o (mem_rdata_o),
`ifdef MEM_CTRL_MISALIGN_CHK_EN
        .mem_misalign_o (mem_misalign_o),
`endif
        .busy_o      (busy_o),
        .ram_din_i   (ram_din_i),
        .ram_addr_o  (ram_addr_o),
        .ram_dout_o  (ram_dout_o),
        .ram_wr_o    (ram_wr_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (tb_we) ram[tb_waddr] <= tb_wdata;
        else if (ram_wr_o) ram[ram_addr_o] <= ram_dout_o;
        ram_din_i <= ram[ram_addr_o];
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", name, got, exp);
        else
            n_pass++;
    endtask

    task automatic poke(input logic [16:0] a, input logic [7:0] d);
        tb_we = 1'b1;
        tb_waddr = a;
        tb_wdata = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // Issue one request, scramble inputs after accept, wait for done.
    task automatic do_req(input bit is_mem, input bit we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input bit sext,
                          input logic [31:0] exp, input int exp_lat,
                          input int exp_wr, input string name);
        int cyc;
        int wrc;
        int other;
        bit seen;
        logic [31:0] got;
        logic [31:0] e;
        sb.push_back(exp);
        if (is_mem) begin
            mem_req_i = 1'b1;
            mem_we_i = we;
            mem_addr_i = addr;
            mem_wdata_i = wdata;
            mem_size_i = size;
            mem_sext_i = sext;
        end else begin
            if_req_i = 1'b1;
            if_addr_i = addr;
        end
        cyc = 0;
        wrc = 0;
        other = 0;
        seen = 1'b0;
        got = '0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (ram_wr_o) wrc++;
            if (cyc == 1) begin
                mem_addr_i = ~addr;
                if_addr_i = ~addr;
                mem_wdata_i = ~wdata;
            end
            if (is_mem ? if_done_o : mem_done_o) other++;
            if (is_mem ? mem_done_o : if_done_o) begin
                seen = 1'b1;
                got = is_mem ? mem_rdata_o : if_data_o;
            end
        end
        if_req_i = 1'b0;
        mem_req_i = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (!seen) $display("FAIL %s_timeout: no done after %0d cycles", name, cyc);
        else n_pass++;
        n_checks++;
        if (cyc !== exp_lat)
            $display("FAIL %s_latency: got %0d expected %0d", name, cyc, exp_lat);
        else n_pass++;
        n_checks++;
        if (wrc !== exp_wr)
            $display("FAIL %s_wrcycles: got %0d expected %0d", name, wrc, exp_wr);
        else n_pass++;
        n_checks++;
        if (other !== 0)
            $display("FAIL %s_otherdone: got %0d expected 0", name, other);
        else n_pass++;
        if (!we) begin
            n_checks++;
            if (got !== e)
                $display("FAIL %s_data: got %h expected %h", name, got, e);
            else n_pass++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_dones", {30'd0, if_done_o, mem_done_o}, 32'd0);
        chk("rst_ram_wr", {31'd0, ram_wr_o}, 32'd0);
        chk("rst_ram_addr", {15'd0, ram_addr_o}, 32'd0);
        chk("rst_if_data", if_data_o, 32'd0);
        chk("rst_mem_rdata", mem_rdata_o, 32'd0);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch;
        poke(17'h0, 8'h13);
        poke(17'h1, 8'h05);
        poke(17'h2, 8'h10);
        poke(17'h3, 8'h00);
        do_req(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0,
               32'h00100513, 6, 0, "fetch");
    endtask

    task automatic test_byte_load;
        poke(17'h104, 8'h80);
        do_req(1'b1, 1'b0, 32'h104, 32'h0, 2'b00, 1'b1,
               32'hFFFFFF80, 3, 0, "lb_sext");
        do_req(1'b1, 1'b0, 32'h104, 32'h0, 2'b00, 1'b0,
               32'h00000080, 3, 0, "lb_zext");
    endtask

    task automatic test_store_load;
        do_req(1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 2'b10, 1'b0,
               32'h0, 5, 4, "sw");
        chk("sw_b0", {24'd0, ram[17'h200]}, 32'hEF);
        chk("sw_b1", {24'd0, ram[17'h201]}, 32'hBE);
        chk("sw_b2", {24'd0, ram[17'h202]}, 32'hAD);
        chk("sw_b3", {24'd0, ram[17'h203]}, 32'hDE);
        do_req(1'b1, 1'b0, 32'h200, 32'h0, 2'b10, 1'b0,
               32'hDEADBEEF, 6, 0, "lw");
    endtask

    task automatic test_half;
        poke(17'h300, 8'h34);
        poke(17'h301, 8'h12);
        poke(17'h302, 8'h56);
        poke(17'h310, 8'h01);
        poke(17'h311, 8'h80);
        do_req(1'b1, 1'b0, 32'h310, 32'h0, 2'b01, 1'b1,
               32'hFFFF8001, 4, 0, "lh_sext");
        do_req(1'b1, 1'b0, 32'h301, 32'h0, 2'b01, 1'b0,
               32'h00005612, 4, 0, "lh_odd");
        do_req(1'b1, 1'b1, 32'h320, 32'hAAAA99CC, 2'b01, 1'b0,
               32'h0, 3, 2, "sh");
        chk("sh_b0", {24'd0, ram[17'h320]}, 32'hCC);
        chk("sh_b1", {24'd0, ram[17'h321]}, 32'h99);
    endtask

    task automatic test_wrap;
        poke(17'h1FFFE, 8'hAA);
        poke(17'h1FFFF, 8'hBB);
        do_req(1'b1, 1'b0, 32'h0001FFFE, 32'h0, 2'b11, 1'b0,
               32'h0513BBAA, 6, 0, "lw_wrap");
    endtask

    task automatic test_back_to_back;
        int cyc;
        int mem_at;
        int if_at;
        logic [31:0] got_m;
        logic [31:0] got_i;
        mem_req_i = 1'b1;
        mem_we_i = 1'b0;
        mem_addr_i = 32'h300;
        mem_size_i = 2'b01;
        mem_sext_i = 1'b0;
        if_req_i = 1'b1;
        if_addr_i = 32'h0;
        cyc = 0;
        mem_at = 0;
        if_at = 0;
        got_m = '0;
        got_i = '0;
        while ((mem_at == 0 || if_at == 0) && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (mem_done_o) begin
                mem_at = cyc;
                mem_req_i = 1'b0;
                got_m = mem_rdata_o;
            end
            if (if_done_o) begin
                if_at = cyc;
                if_req_i = 1'b0;
                got_i = if_data_o;
            end
        end
        mem_req_i = 1'b0;
        if_req_i = 1'b0;
        chk("both_mem_at", mem_at, 32'd4);
        chk("both_if_at", if_at, 32'd11);
        chk("both_mem_data", got_m, 32'h00001234);
        chk("both_if_data", got_i, 32'h00100513);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write;
        int dones;
        poke(17'h400, 8'h00);
        poke(17'h401, 8'h00);
        poke(17'h402, 8'h00);
        poke(17'h403, 8'h00);
        mem_req_i = 1'b1;
        mem_we_i = 1'b1;
        mem_addr_i = 32'h400;
        mem_wdata_i = 32'h11223344;
        mem_size_i = 2'b10;
        mem_sext_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_wr_active", {31'd0, ram_wr_o}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_ram_wr", {31'd0, ram_wr_o}, 32'd0);
        chk("mid_busy", {31'd0, busy_o}, 32'd0);
        chk("mid_ram_addr", {15'd0, ram_addr_o}, 32'd0);
        chk("mid_ram_dout", {24'd0, ram_dout_o}, 32'd0);
        chk("mid_mem_rdata", mem_rdata_o, 32'd0);
        chk("mid_if_data", if_data_o, 32'd0);
        mem_req_i = 1'b0;
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_done_o || if_done_o) dones++;
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (mem_done_o || if_done_o) dones++;
        end
        chk("mid_no_done", dones, 32'd0);
        chk("mid_b0", {24'd0, ram[17'h400]}, 32'h44);
        chk("mid_b1", {24'd0, ram[17'h401]}, 32'h33);
        chk("mid_b2", {24'd0, ram[17'h402]}, 32'h00);
        chk("mid_idle", {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        rst = 1'b0;
        tb_we = 1'b0;
        tb_waddr = '0;
        tb_wdata = '0;
        if_req_i = 1'b0;
        if_addr_i = '0;
        mem_req_i = 1'b0;
        mem_we_i = 1'b0;
        mem_addr_i = '0;
        mem_wdata_i = '0;
        mem_size_i = 2'b00;
        mem_sext_i = 1'b0;
        @(negedge clk);
        test_reset;
        test_fetch;
        test_byte_load;
        test_store_load;
        test_half;
        test_wrap;
        test_back_to_back;
        test_reset_mid_write;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
